// File: rtl/r200_pkg.sv
// r200_pkg: shared decode/execute definitions for the R200 pipeline.
// Holds opcode constants, operand-2 select and writeback select encodings,
// the decoded control bundle, and the opcode-to-control decode function.
package r200_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Operand 2 source
    typedef enum logic [2:0] {
        OP2_RS2  = 3'd0,
        OP2_IMMI = 3'd1,
        OP2_IMMS = 3'd2,
        OP2_PC4  = 3'd3,
        OP2_PC   = 3'd4
    } op2sel_e;

    // Writeback source seen by execute: ALU result, memory, link (op2 = pc+4), op1 pass-through
    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2,
        WB_OP1  = 2'd3
    } wbsel_e;

    typedef struct packed {
        logic    legal;
        logic    rs1_used;
        logic    rs2_used;
        logic    rs2_lo;     // rs2 index taken from instrn[11:7]
        logic    op1_uimm;
        op2sel_e op2sel;
        wbsel_e  wbsel;
        logic    regwr;
        logic    memwr;
        logic    funcsel;    // 1: funct3 selects the ALU function, 0: plain add
        logic    alu_cont;   // sub / arithmetic-shift modifier
        logic    isbr;
        logic    willjmp;
        logic    link;       // rd forced to x1
    } ctrl_t;

    // Opcode-level control decode; register-range legality is checked by the caller.
    function automatic ctrl_t decode_ctrl(input logic [31:0] instrn);
        ctrl_t c;
        c        = '0;
        c.op2sel = OP2_RS2;
        c.wbsel  = WB_ALU;
        case (instrn[6:0])
            OPC_LUI: begin
                c.legal = 1'b1; c.regwr = 1'b1; c.op1_uimm = 1'b1;
                c.op2sel = OP2_PC4; c.wbsel = WB_OP1;
            end
            OPC_AUIPC: begin
                c.legal = 1'b1; c.regwr = 1'b1; c.op1_uimm = 1'b1;
                c.op2sel = OP2_PC;
            end
            OPC_OP: begin
                c.legal = 1'b1; c.regwr = 1'b1; c.rs1_used = 1'b1; c.rs2_used = 1'b1;
                c.funcsel = 1'b1; c.alu_cont = instrn[30];
            end
            OPC_OPIMM: begin
                c.legal = 1'b1; c.regwr = 1'b1; c.rs1_used = 1'b1;
                c.op2sel = OP2_IMMI; c.funcsel = 1'b1;
                c.alu_cont = (instrn[14:12] == 3'b101) & instrn[30];
            end
            OPC_LOAD: begin
                c.legal = 1'b1; c.regwr = 1'b1; c.rs1_used = 1'b1;
                c.op2sel = OP2_IMMI; c.wbsel = WB_MEM;
            end
            OPC_STORE: begin
                c.legal = 1'b1; c.memwr = 1'b1; c.rs1_used = 1'b1; c.rs2_used = 1'b1;
                c.rs2_lo = 1'b1; c.op2sel = OP2_IMMS;
            end
            OPC_BRANCH: begin
                c.legal = 1'b1; c.isbr = 1'b1; c.rs1_used = 1'b1; c.rs2_used = 1'b1;
                c.rs2_lo = 1'b1;
            end
            OPC_JAL: begin
                c.legal = 1'b1; c.regwr = 1'b1; c.willjmp = 1'b1; c.link = 1'b1;
                c.op2sel = OP2_PC4; c.wbsel = WB_LINK;
            end
            OPC_JALR: begin
                c.legal = 1'b1; c.regwr = 1'b1; c.willjmp = 1'b1; c.link = 1'b1;
                c.rs1_used = 1'b1; c.op2sel = OP2_PC4; c.wbsel = WB_LINK;
            end
            default: c.legal = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/r200_regfile.sv
// r200_regfile: NREG x XLEN register file, two combinational read ports,
// one synchronous write port. x0 reads zero and ignores writes.
// Ports: clk, rst (sync, active-high, clears all registers),
//        wb_en_i/wb_addr_i/wb_data_i write port,
//        ra1_i/rd1_o and ra2_i/rd2_o read ports.
module r200_regfile #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_en_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic [AW-1:0]   ra1_i,
    output logic [XLEN-1:0] rd1_o,
    input  logic [AW-1:0]   ra2_i,
    output logic [XLEN-1:0] rd2_o
);

    logic [XLEN-1:0] regs_q [NREG];

    // Storage; reset wins over writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en_i && (wb_addr_i != '0)) begin
            regs_q[wb_addr_i] <= wb_data_i;
        end
    end

    // Read ports with optional same-cycle write-through
    always_comb begin
        rd1_o = regs_q[ra1_i];
        rd2_o = regs_q[ra2_i];
        if ((BYPASS != 0) && wb_en_i && (wb_addr_i == ra1_i)) rd1_o = wb_data_i;
        if ((BYPASS != 0) && wb_en_i && (wb_addr_i == ra2_i)) rd2_o = wb_data_i;
        if (ra1_i == '0) rd1_o = '0;
        if (ra2_i == '0) rd2_o = '0;
    end

endmodule

// File: rtl/r200_id_stage.sv
// r200_id_stage: R200 instruction decode stage with register file read,
// load-use hazard detection and a one-entry registered output towards execute.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_instrn/in_pc from fetch;
//        wb_en/wb_addr/wb_data writeback; ex_isload/ex_rd load in execute; flush;
//        out_valid/ex_ready handshake plus registered operand and control outputs.
module r200_id_stage
    import r200_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instrn,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_isload,
    input  logic [AW-1:0]   ex_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [XLEN-1:0] out_rs2o,
    output logic [XLEN-1:0] out_brtarg,
    output logic [AW-1:0]   out_rdaddr,
    output logic            out_regwr,
    output logic            out_memwr,
    output logic            out_funcsel,
    output logic            out_alu_cont,
    output logic            out_isbr,
    output logic            out_willjmp,
    output logic            out_illegal,
    output logic [1:0]      out_wbsel
);

    ctrl_t           ctrl_c;
    logic [4:0]      rs1_f_c, rs2_f_c, rd_f_c;
    logic [AW-1:0]   rs1_a_c, rs2_a_c, rd_a_c;
    logic [XLEN-1:0] rdata1_c, rdata2_c;
    logic [XLEN-1:0] imm_i_c, imm_s_c, imm_b_c, imm_j_c, imm_u_c, pc4_c;
    logic [XLEN-1:0] op1_c, op2_c, brtarg_c;
    logic            range_bad_c, illegal_c, hazard_c, accept_c;

    function automatic logic idx_ok(input logic [4:0] f);
        return 32'(f) < NREG;
    endfunction

    assign ctrl_c = decode_ctrl(in_instrn);

    // Register indices; link instructions always write x1
    assign rs1_f_c = in_instrn[19:15];
    assign rs2_f_c = ctrl_c.rs2_lo ? in_instrn[11:7] : in_instrn[24:20];
    assign rd_f_c  = in_instrn[11:7];
    assign rs1_a_c = rs1_f_c[AW-1:0];
    assign rs2_a_c = rs2_f_c[AW-1:0];
    assign rd_a_c  = ctrl_c.link ? AW'(1) : rd_f_c[AW-1:0];

    // Only fields the instruction actually uses can make it illegal
    assign range_bad_c = (ctrl_c.rs1_used & ~idx_ok(rs1_f_c))
                       | (ctrl_c.rs2_used & ~idx_ok(rs2_f_c))
                       | (ctrl_c.regwr & ~ctrl_c.link & ~idx_ok(rd_f_c));
    assign illegal_c   = ~ctrl_c.legal | range_bad_c;

    r200_regfile #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .BYPASS (BYPASS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wb_en_i   (wb_en),
        .wb_addr_i (wb_addr),
        .wb_data_i (wb_data),
        .ra1_i     (rs1_a_c),
        .rd1_o     (rdata1_c),
        .ra2_i     (rs2_a_c),
        .rd2_o     (rdata2_c)
    );

    // Sign-extended immediates
    assign imm_i_c = XLEN'($signed(in_instrn[31:20]));
    assign imm_s_c = XLEN'($signed({in_instrn[31:25], in_instrn[11:7]}));
    assign imm_b_c = XLEN'($signed({in_instrn[31], in_instrn[7], in_instrn[30:25],
                                    in_instrn[11:8], 1'b0}));
    assign imm_j_c = XLEN'($signed({in_instrn[31], in_instrn[19:12], in_instrn[20],
                                    in_instrn[30:21], 1'b0}));
    assign imm_u_c = XLEN'($signed({in_instrn[31:12], 12'b0}));
    assign pc4_c   = in_pc + XLEN'(4);

    // Operand and target selection; JAL/JALR targets share the brtarg output
    always_comb begin
        op1_c = ctrl_c.op1_uimm ? imm_u_c : rdata1_c;
        case (ctrl_c.op2sel)
            OP2_IMMI: op2_c = imm_i_c;
            OP2_IMMS: op2_c = imm_s_c;
            OP2_PC4:  op2_c = pc4_c;
            OP2_PC:   op2_c = in_pc;
            default:  op2_c = rdata2_c;
        endcase
        if (ctrl_c.link && ctrl_c.rs1_used) brtarg_c = rdata1_c + imm_i_c;
        else if (ctrl_c.link)               brtarg_c = in_pc + imm_j_c;
        else                                brtarg_c = in_pc + imm_b_c;
    end

    // Load-use hazard against the load sitting in execute
    assign hazard_c = ex_isload && (ex_rd != '0)
                   && ((ctrl_c.rs1_used && (ex_rd == rs1_a_c))
                    || (ctrl_c.rs2_used && (ex_rd == rs2_a_c)));

    assign in_ready = ~rst & (flush | ((~out_valid | ex_ready) & ~hazard_c));
    assign accept_c = in_valid & in_ready & ~flush;

    // Output register: reset > flush > accept > drain
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_op1      <= '0;
            out_op2      <= '0;
            out_rs2o     <= '0;
            out_brtarg   <= '0;
            out_rdaddr   <= '0;
            out_regwr    <= 1'b0;
            out_memwr    <= 1'b0;
            out_funcsel  <= 1'b0;
            out_alu_cont <= 1'b0;
            out_isbr     <= 1'b0;
            out_willjmp  <= 1'b0;
            out_illegal  <= 1'b0;
            out_wbsel    <= 2'b00;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept_c) begin
            out_valid    <= 1'b1;
            out_op1      <= op1_c;
            out_op2      <= op2_c;
            out_rs2o     <= rdata2_c;
            out_brtarg   <= brtarg_c;
            out_rdaddr   <= rd_a_c;
            out_regwr    <= ctrl_c.regwr & ~illegal_c;
            out_memwr    <= ctrl_c.memwr & ~illegal_c;
            out_funcsel  <= ctrl_c.funcsel;
            out_alu_cont <= ctrl_c.alu_cont;
            out_isbr     <= ctrl_c.isbr & ~illegal_c;
            out_willjmp  <= ctrl_c.willjmp & ~illegal_c;
            out_illegal  <= illegal_c;
            out_wbsel    <= 2'(ctrl_c.wbsel);
        end else if (ex_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_r200_id_stage.sv
// Directed bench for r200_id_stage: one BYPASS=1 and one BYPASS=0 instance
// driven by the same stimulus.
module tb_r200_id_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, wb_en, ex_isload, flush, ex_ready;
    logic [31:0] in_instrn, in_pc, wb_data;
    logic [4:0]  wb_addr, ex_rd;

    logic        in_ready, out_valid, out_regwr, out_memwr, out_funcsel, out_alu_cont;
    logic        out_isbr, out_willjmp, out_illegal;
    logic [31:0] out_op1, out_op2, out_rs2o, out_brtarg;
    logic [4:0]  out_rdaddr;
    logic [1:0]  out_wbsel;

    logic        nb_in_ready, nb_out_valid, nb_out_regwr, nb_out_memwr, nb_out_funcsel;
    logic        nb_out_alu_cont, nb_out_isbr, nb_out_willjmp, nb_out_illegal;
    logic [31:0] nb_out_op1, nb_out_op2, nb_out_rs2o, nb_out_brtarg;
    logic [4:0]  nb_out_rdaddr;
    logic [1:0]  nb_out_wbsel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    r200_id_stage #(.XLEN(32), .NREG(32), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instrn(in_instrn), .in_pc(in_pc), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .ex_isload(ex_isload), .ex_rd(ex_rd), .flush(flush),
        .out_valid(out_valid), .ex_ready(ex_ready), .out_op1(out_op1), .out_op2(out_op2),
        .out_rs2o(out_rs2o), .out_brtarg(out_brtarg), .out_rdaddr(out_rdaddr),
        .out_regwr(out_regwr), .out_memwr(out_memwr), .out_funcsel(out_funcsel),
        .out_alu_cont(out_alu_cont), .out_isbr(out_isbr), .out_willjmp(out_willjmp),
        .out_illegal(out_illegal), .out_wbsel(out_wbsel)
    );

    r200_id_stage #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nb_in_ready),
        .in_instrn(in_instrn), .in_pc(in_pc), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .ex_isload(ex_isload), .ex_rd(ex_rd), .flush(flush),
        .out_valid(nb_out_valid), .ex_ready(ex_ready), .out_op1(nb_out_op1),
        .out_op2(nb_out_op2), .out_rs2o(nb_out_rs2o), .out_brtarg(nb_out_brtarg),
        .out_rdaddr(nb_out_rdaddr), .out_regwr(nb_out_regwr), .out_memwr(nb_out_memwr),
        .out_funcsel(nb_out_funcsel), .out_alu_cont(nb_out_alu_cont),
        .out_isbr(nb_out_isbr), .out_willjmp(nb_out_willjmp),
        .out_illegal(nb_out_illegal), .out_wbsel(nb_out_wbsel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] add_r(input int rd, input int rs1, input int rs2);
        return (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h33;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instrn = 32'h0; in_pc = 32'h0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
        ex_isload = 1'b0; ex_rd = 5'd0; flush = 1'b0; ex_ready = 1'b1;

        // Reset state
        step(); step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_illegal", 32'(out_illegal), 32'd0);
        chk("rst_op1", out_op1, 32'h0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_ready", 32'(in_ready), 32'd1);

        // Same-cycle writeback bypass vs. no bypass
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        in_valid = 1'b1; in_instrn = add_r(6, 5, 0); in_pc = 32'h40;
        step();
        chk("byp_op1", out_op1, 32'hDEADBEEF);
        chk("nobyp_op1", nb_out_op1, 32'h0);
        chk("byp_valid", 32'(out_valid), 32'd1);
        chk("byp_rd", 32'(out_rdaddr), 32'd6);
        chk("byp_regwr", 32'(out_regwr), 32'd1);
        chk("byp_wbsel", 32'(out_wbsel), 32'd0);
        wb_addr = 5'd2; wb_data = 32'h22;
        step();
        chk("after_wr_op1", out_op1, 32'hDEADBEEF);
        chk("nobyp_after_wr_op1", nb_out_op1, 32'hDEADBEEF);

        // Load-use hazard on rs1 = x3
        wb_addr = 5'd3; wb_data = 32'h33;
        in_instrn = add_r(4, 3, 2); ex_isload = 1'b1; ex_rd = 5'd3;
        #1;
        chk("haz_ready", 32'(in_ready), 32'd0);
        step();
        wb_en = 1'b0;
        chk("haz_bubble1", 32'(out_valid), 32'd0);
        chk("haz_ready2", 32'(in_ready), 32'd0);
        step();
        chk("haz_bubble2", 32'(out_valid), 32'd0);
        ex_isload = 1'b0;
        #1;
        chk("haz_release_ready", 32'(in_ready), 32'd1);
        step();
        chk("haz_accept_valid", 32'(out_valid), 32'd1);
        chk("haz_accept_rd", 32'(out_rdaddr), 32'd4);
        chk("haz_accept_op1", out_op1, 32'h33);
        chk("haz_accept_op2", out_op2, 32'h22);

        // Backpressure for three cycles, then back-to-back transfers
        ex_ready = 1'b0; in_instrn = add_r(7, 5, 2); in_pc = 32'h48;
        #1;
        chk("stall_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_rd", 32'(out_rdaddr), 32'd4);
            chk("stall_op1", out_op1, 32'h33);
            chk("stall_ready_hold", 32'(in_ready), 32'd0);
        end
        ex_ready = 1'b1;
        #1;
        chk("unstall_ready", 32'(in_ready), 32'd1);
        step();
        chk("b2b1_valid", 32'(out_valid), 32'd1);
        chk("b2b1_rd", 32'(out_rdaddr), 32'd7);
        chk("b2b1_op1", out_op1, 32'hDEADBEEF);
        in_instrn = add_r(8, 0, 0);
        step();
        chk("b2b2_valid", 32'(out_valid), 32'd1);
        chk("b2b2_rd", 32'(out_rdaddr), 32'd8);

        // Flush beats a stall and drops the presented beat; writeback still lands
        ex_ready = 1'b0; flush = 1'b1; in_instrn = add_r(9, 0, 0);
        wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h12345678;
        #1;
        chk("flush_ready", 32'(in_ready), 32'd1);
        step();
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_dropped_rd", 32'(out_rdaddr), 32'd8);
        flush = 1'b0; wb_en = 1'b0; ex_ready = 1'b1; in_instrn = add_r(11, 10, 0);
        step();
        chk("flush_wr_op1", out_op1, 32'h12345678);
        chk("flush_next_rd", 32'(out_rdaddr), 32'd11);

        // Branch target, illegal opcode, JAL link, immediates
        in_instrn = 32'hFE000CE3; in_pc = 32'h100;
        step();
        chk("beq_brtarg", out_brtarg, 32'hF8);
        chk("beq_isbr", 32'(out_isbr), 32'd1);
        chk("beq_regwr", 32'(out_regwr), 32'd0);
        chk("beq_illegal", 32'(out_illegal), 32'd0);
        in_instrn = 32'h0000007F;
        step();
        chk("ill_illegal", 32'(out_illegal), 32'd1);
        chk("ill_regwr", 32'(out_regwr), 32'd0);
        chk("ill_memwr", 32'(out_memwr), 32'd0);
        chk("ill_willjmp", 32'(out_willjmp), 32'd0);
        in_instrn = 32'h0100006F; in_pc = 32'h200;
        step();
        chk("jal_rd", 32'(out_rdaddr), 32'd1);
        chk("jal_willjmp", 32'(out_willjmp), 32'd1);
        chk("jal_op2", out_op2, 32'h204);
        chk("jal_brtarg", out_brtarg, 32'h210);
        chk("jal_wbsel", 32'(out_wbsel), 32'd2);
        chk("jal_illegal", 32'(out_illegal), 32'd0);
        in_instrn = 32'hFFF00293;
        step();
        chk("addi_op2", out_op2, 32'hFFFFFFFF);
        chk("addi_funcsel", 32'(out_funcsel), 32'd1);
        in_instrn = 32'h123451B7;
        step();
        chk("lui_op1", out_op1, 32'h12345000);
        chk("lui_wbsel", 32'(out_wbsel), 32'd3);
        chk("lui_rd", 32'(out_rdaddr), 32'd3);

        // Reset in the middle of a stall
        ex_ready = 1'b0; in_instrn = add_r(6, 5, 0);
        step();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(in_ready), 32'd0);
        step();
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        step();
        rst = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
        step();
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        for (int i = 1; i < 32; i++) begin
            in_instrn = add_r(1, i, i);
            step();
            chk($sformatf("rst_x%0d_op1", i), out_op1, 32'h0);
            chk($sformatf("rst_x%0d_op2", i), out_op2, 32'h0);
        end
        in_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/r200_id_stage.md
R200_ID_STAGE -- requirements
Module: r200_id_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/register width (>=32).
REQ-002 SHALL have parameter NREG, default 32, architectural register count (power of two, 16 or 32); AW = log2(NREG).
REQ-003 SHALL have parameter BYPASS, default 1, enables write-through of the writeback port to same-cycle reads.
REQ-004 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1  fetch-to-decode handshake.
REQ-007 SHALL have ports in_instrn input 32, in_pc input XLEN  instruction and its address.
REQ-008 SHALL have ports wb_en input 1, wb_addr input AW, wb_data input XLEN  register writeback.
REQ-009 SHALL have ports ex_isload input 1, ex_rd input AW  load currently held in execute.
REQ-010 SHALL have port flush  input  1  kill the decode output and any accepted beat.
REQ-011 SHALL have ports out_valid output 1, ex_ready input 1  decode-to-execute handshake.
REQ-012 SHALL have registered outputs out_op1, out_op2, out_rs2o, out_brtarg (XLEN each), out_rdaddr (AW), out_regwr, out_memwr, out_funcsel, out_alu_cont, out_isbr, out_willjmp, out_illegal (1 each), out_wbsel (2).

Function
REQ-013 SHALL decode opcodes LUI, AUIPC, OP, OP-IMM, LOAD, STORE, BRANCH, JAL and JALR into control fields identical in meaning to the existing decoder; op1 = rs1 or U-imm; op2 = rs2, I-imm, S-imm or pc+4.
REQ-014 SHALL sign-extend all immediates from their instruction fields to XLEN; out_brtarg = in_pc + sign-extended B-imm, modulo 2^XLEN.
REQ-015 SHALL select the rs2 read address from instrn[24:20], or instrn[11:7] for store/branch as the existing decoder does; rd = x1 for JAL/JALR link.
REQ-016 SHALL, for an unrecognised opcode or a register index >= NREG, set out_illegal=1 with out_regwr=0, out_memwr=0, out_isbr=0, out_willjmp=0.
REQ-017 SHALL read x0 as zero and ignore writes to x0.
REQ-018 SHALL write wb_data to wb_addr on every clock with wb_en=1, independent of stall or flush.
REQ-019 SHALL, when BYPASS=1, return wb_data for a same-cycle read of wb_addr (nonzero, wb_en=1); when BYPASS=0, return the old value.
REQ-020 SHALL assert load-use hazard when ex_isload=1, ex_rd!=0 and ex_rd equals rs1 (if used) or rs2 (if used).
REQ-021 SHALL drive in_ready = flush | ((~out_valid | ex_ready) & ~hazard), combinationally.
REQ-022 SHALL load the output register and set out_valid=1 on the clock where in_valid & in_ready & ~flush; latency one cycle.
REQ-023 SHALL clear out_valid when ex_ready=1 and no new beat is accepted; SHALL hold all outputs stable while out_valid=1 and ex_ready=0.
REQ-024 SHALL, on flush=1, clear out_valid next cycle and discard any beat presented that cycle; flush has priority over accept and hazard.
REQ-025 SHALL insert exactly one bubble (out_valid=0) per cycle the hazard persists, keeping the instruction in fetch.

Reset
REQ-026 SHALL, on rst=1, clear out_valid, out_illegal and all control outputs to 0, data outputs to 0, and all registers x1..xNREG-1 to 0.
REQ-027 SHALL give rst priority over flush, writeback and accept; in_ready SHALL be 0 while rst=1.

Structure
REQ-028 SHALL place opcode constants, the op2sel encoding and the wbsel encoding in a shared package r200_pkg, used by decode and execute.
REQ-029 SHALL implement the register file as one sub-module r200_regfile (parameters XLEN, NREG, BYPASS; two read ports, one write port).
REQ-030 SHALL use no latches and no asynchronous logic.

Verification
REQ-031 SHALL test: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF with ADD reading x5 same cycle -> out_op1=0xDEADBEEF next cycle (BYPASS=1), 0 (BYPASS=0).
REQ-032 SHALL test: ex_isload=1, ex_rd=3, instruction ADD x4,x3,x2 -> in_ready=0, one bubble, accept after ex_isload drops.
REQ-033 SHALL test: out_valid=1, ex_ready=0 for 3 cycles -> outputs unchanged, in_ready=0; then ex_ready=1 with new beat -> back-to-back transfer.
REQ-034 SHALL test: flush=1 with in_valid=1 -> out_valid=0 next cycle, beat dropped, regfile write still performed.
REQ-035 SHALL test: BEQ at pc=0x100 with B-imm=-8 -> out_brtarg=0xF8, out_isbr=1; opcode 0x7F -> out_illegal=1, out_regwr=0.
REQ-036 SHALL test: rst=1 mid-stall -> out_valid=0, x1..x31 read 0 after release.
